// File: rtl/qk_inst_sequencer.sv
// qk_inst_sequencer: generates the fullchip inst/mem_in stream for one Q.K attention pass
// Ports:
//    clk, reset (async, active-low)
//    start     begin a pass (sampled in IDLE only)
//    abort     synchronous return to IDLE from any state
//    in_valid/in_data/in_ready  upstream Q/K row stream, element 0 in LSBs
//    mem_in    registered row to fullchip
//    inst      registered 17-bit fullchip instruction word
//    busy      high whenever not IDLE
//    done      one-cycle pass-complete pulse
//    phase     current state encoding
module qk_inst_sequencer #(
   parameter int TOTAL = 8,
   parameter int COL   = 8,
   parameter int PR    = 8,
   parameter int BW    = 8,
   parameter int GAP   = 10,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               in_valid,
   input  logic [PR*BW-1:0]   in_data,
   output logic               in_ready,
   output logic [PR*BW-1:0]   mem_in,
   output logic [16:0]        inst,
   output logic               busy,
   output logic               done,
   output logic [3:0]         phase
);
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_QWR   = 4'd1,
      S_KWR   = 4'd2,
      S_KLOAD = 4'd3,
      S_GAP   = 4'd4,
      S_EXEC  = 4'd5,
      S_MOVE  = 4'd6,
      S_PRD   = 4'd7,
      S_DONE  = 4'd8
   } state_t;
   localparam int CW = 8;
   localparam logic [CW-1:0] T_LAST = CW'(TOTAL - 1);
   localparam logic [CW-1:0] C_LAST = CW'(COL - 1);
   localparam logic [CW-1:0] C_END  = CW'(COL);
   localparam logic [CW-1:0] K_LAST = CW'(COL + 1);
   localparam logic [CW-1:0] G_LAST = CW'(GAP - 1);
   state_t             state_q, state_d, ret_q, ret_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [16:0]        inst_q, inst_d;
   logic [PR*BW-1:0]   mem_q, mem_d;
   logic               done_q, done_d;
   logic [AW-1:0]      add, km1;
   logic               last;
   assign add      = cnt_q[AW-1:0];
   assign km1      = add - AW'(1);
   assign in_ready = (state_q == S_QWR) || (state_q == S_KWR);
   assign mem_in   = mem_q;
   assign inst     = inst_q;
   assign busy     = state_q != S_IDLE;
   assign done     = done_q;
   assign phase    = state_q;
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      inst_d  = '0;
      mem_d   = mem_q;
      done_d  = 1'b0;
      last    = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         ret_d   = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = start ? S_QWR : S_IDLE;
               cnt_d   = '0;
            end
            S_QWR, S_KWR: begin
               // a missing beat is a stall: nothing issued, address held
               if (in_valid) begin
                  last           = (state_q == S_QWR) ? (cnt_q == T_LAST) : (cnt_q == C_LAST);
                  inst_d[4]      = state_q == S_QWR;
                  inst_d[2]      = state_q == S_KWR;
                  inst_d[15:12]  = add;
                  mem_d          = in_data;
                  cnt_d          = last ? '0 : cnt_q + CW'(1);
                  state_d        = !last ? state_q : (state_q == S_QWR) ? S_KWR : S_KLOAD;
               end
            end
            S_KLOAD: begin
               // load framed by one idle-address cycle on each side of the kmem reads
               last      = cnt_q == K_LAST;
               inst_d[6] = 1'b1;
               if (cnt_q != '0 && cnt_q <= C_END) begin
                  inst_d[3]     = 1'b1;
                  inst_d[15:12] = km1;
               end
               cnt_d   = last ? '0 : cnt_q + CW'(1);
               state_d = last ? S_GAP : S_KLOAD;
               ret_d   = S_EXEC;
            end
            S_GAP: begin
               last    = cnt_q == G_LAST;
               cnt_d   = last ? '0 : cnt_q + CW'(1);
               state_d = last ? ret_q : S_GAP;
            end
            S_EXEC: begin
               last          = cnt_q == T_LAST;
               inst_d[7]     = 1'b1;
               inst_d[5]     = 1'b1;
               inst_d[15:12] = add;
               cnt_d         = last ? '0 : cnt_q + CW'(1);
               state_d       = last ? S_GAP : S_EXEC;
               ret_d         = S_MOVE;
            end
            S_MOVE: begin
               last         = cnt_q == T_LAST;
               inst_d[16]   = 1'b1;
               inst_d[0]    = 1'b1;
               inst_d[11:8] = add;
               cnt_d        = last ? '0 : cnt_q + CW'(1);
               state_d      = last ? S_GAP : S_MOVE;
               ret_d        = S_PRD;
            end
            S_PRD: begin
               last         = cnt_q == T_LAST;
               inst_d[1]    = 1'b1;
               inst_d[11:8] = add;
               cnt_d        = last ? '0 : cnt_q + CW'(1);
               state_d      = last ? S_DONE : S_PRD;
            end
            S_DONE: begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
            default: begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         cnt_q   <= '0;
         inst_q  <= '0;
         mem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         mem_q   <= mem_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_qk_inst_sequencer.sv
// tb_qk_inst_sequencer: scoreboard bench for qk_inst_sequencer
module tb_qk_inst_sequencer;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_ready, busy, done;
   logic [63:0] mem_in;
   logic [16:0] inst;
   logic [3:0]  phase;
   int          edge_n = 0, checks = 0, fails = 0;
   typedef struct {
      int          stamp;
      logic [16:0] inst;
      logic [63:0] mem;
      logic        done;
   } exp_t;
   exp_t        sb[$];
   exp_t        m_e;
   logic [63:0] q_row[8], k_row[8];
   qk_inst_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_in(mem_in), .inst(inst), .busy(busy), .done(done), .phase(phase)
   );
   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask
   function automatic void push(input int st, input logic [16:0] iw, input logic [63:0] m, input logic d);
      exp_t e;
      e.stamp = st;
      e.inst  = iw;
      e.mem   = m;
      e.done  = d;
      sb.push_back(e);
   endfunction
   function automatic logic [16:0] w(input int qa, input int pa, input logic [7:0] cmd, input logic of);
      return {of, qa[3:0], pa[3:0], cmd};
   endfunction
   // every non-idle output word is matched, in order, against the queued expectation
   always @(negedge clk) begin
      if (reset && (inst != '0 || done)) begin
         if (sb.size() == 0) chk("unexpected_out", {46'b0, done, inst}, 64'b0);
         else begin
            m_e = sb.pop_front();
            chk("out_edge", edge_n, m_e.stamp);
            chk("inst", inst, m_e.inst);
            chk("mem_in", mem_in, m_e.mem);
            chk("done", done, m_e.done);
         end
      end
   end
   task automatic pass(input bit tog, input bit poke, input bit junk, input bit ab);
      int s, b, n;
      bit fin;
      n   = 0;
      fin = 0;
      @(negedge clk);
      start = 1'b1;
      s = edge_n + 1;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = p != 0 ? k_row[i] : q_row[i];
            push(edge_n + 1, w(i, 0, p != 0 ? 8'h04 : 8'h10, 1'b0), in_data, 1'b0);
            @(negedge clk);
            if (tog && p == 0 && i < 7) begin
               in_valid = 1'b0;
               in_data  = 64'hFFFF_0000_FFFF_0000;
               n++;
               @(negedge clk);
            end
         end
      end
      b        = s + n;
      in_valid = junk;
      in_data  = 64'h5A5A_A5A5_5A5A_A5A5;
      push(b + 17, w(0, 0, 8'h40, 1'b0), k_row[7], 1'b0);
      for (int j = 0; j < 8; j++) push(b + 18 + j, w(j, 0, 8'h48, 1'b0), k_row[7], 1'b0);
      push(b + 26, w(0, 0, 8'h40, 1'b0), k_row[7], 1'b0);
      for (int i = 0; i < 8; i++) push(b + 37 + i, w(i, 0, 8'hA0, 1'b0), k_row[7], 1'b0);
      for (int i = 0; i < (ab ? 4 : 8); i++) push(b + 55 + i, w(0, i, 8'h01, 1'b1), k_row[7], 1'b0);
      if (!ab) begin
         for (int i = 0; i < 8; i++) push(b + 73 + i, w(0, i, 8'h02, 1'b0), k_row[7], 1'b0);
         push(b + 81, 17'h0, k_row[7], 1'b1);
      end
      for (int c = 0; c < 100 && !fin; c++) begin
         @(negedge clk);
         start = poke && edge_n == b + 39;
         abort = ab && edge_n == b + 58;
         if (edge_n == b + 30) begin
            chk("gap_busy", busy, 1);
            chk("gap_phase", phase, 4);
         end
         if (junk && (edge_n == b + 20 || edge_n == b + 40)) chk("idle_in_ready", in_ready, 0);
         if (ab && edge_n == b + 59) begin
            chk("abort_inst", inst, 0);
            chk("abort_phase", phase, 0);
            chk("abort_done", done, 0);
            fin = 1;
         end
         if (!ab && edge_n == b + 81) begin
            chk("done_phase", phase, 0);
            chk("done_busy", busy, 0);
            fin = 1;
         end
      end
      chk("pass_end", fin, 1);
      in_valid = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      repeat (3) @(negedge clk);
      chk("pass_drain", sb.size(), 0);
      chk("post_done", done, 0);
   endtask
   initial begin
      for (int i = 0; i < 8; i++) begin
         q_row[i] = 64'h1000_0000_0000_0000 + 64'(i + 1) * 64'h0101_0101_0101_0101;
         k_row[i] = 64'h8000_0000_0000_0000 + 64'(i + 1) * 64'h0102_0304_0506_0708;
      end
      repeat (2) @(negedge clk);
      chk("rst_inst", inst, 0);
      chk("rst_mem_in", mem_in, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_phase", phase, 0);
      reset = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = q_row[i];
         push(edge_n + 1, w(i, 0, 8'h10, 1'b0), q_row[i], 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("qwr_in_ready", in_ready, 1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_inst", inst, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mem_in", mem_in, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      pass(0, 0, 0, 0);
      pass(1, 0, 0, 0);
      pass(0, 1, 0, 0);
      pass(0, 0, 0, 1);
      pass(0, 0, 0, 0);
      pass(0, 0, 1, 0);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
